// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
// Optional feature macro UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period divider, pulses bit_done on the last clk of each bit.
// Ports: clk, rst (async, active-high), clr (restart the period), bit_done (one-cycle pulse).
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign bit_done = cnt == LAST;
  // Wraps on its own so consecutive data bits share one running period.
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else     cnt <= (clr | bit_done) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 (or 8E1 with UART_TX_PARITY_EN) serial transmitter, LSB first.
// Ports: clk, rst (async, active-high), tx_data/tx_valid/tx_ready byte handshake,
//        tx (registered serial line, idles high), tx_busy (= ~tx_ready).
// Macro UART_TX_PARITY_EN: insert an even-parity bit between data bit 7 and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   tx_busy
);
  localparam int IDX_W = $clog2(UART_DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_W - 1);
  uart_tx_state_t state, state_n;
  logic [UART_DATA_W-1:0] sr, sr_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic tx_n, bit_done, clr;
`ifdef UART_TX_PARITY_EN
  logic par, par_n;
  // Parity is latched at capture since the shift register consumes the byte.
  assign par_n = (tx_ready & tx_valid) ? ^tx_data : par;
`endif
  assign tx_ready = state == IDLE;
  assign tx_busy  = ~tx_ready;
  // Hold the divider cleared while idle and restart it on every state change.
  assign clr = (state_n != state) | tx_ready;
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .rst(rst), .clr(clr), .bit_done(bit_done)
  );
  always_comb begin
    state_n = state;
    sr_n    = sr;
    idx_n   = idx;
    unique case (state)
      IDLE: if (tx_valid) begin
        state_n = START;
        sr_n    = tx_data;
        idx_n   = '0;
      end
      START: if (bit_done) state_n = DATA;
      DATA: if (bit_done) begin
        sr_n  = sr >> 1;
        idx_n = idx + 1'b1;
`ifdef UART_TX_PARITY_EN
        if (idx == IDX_LAST) state_n = PARITY;
`else
        if (idx == IDX_LAST) state_n = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) state_n = STOP;
`endif
      STOP: if (bit_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // tx is registered from the next-state view so the line changes on the same edge as the state.
`ifdef UART_TX_PARITY_EN
    tx_n = state_n == START  ? 1'b0 :
           state_n == DATA   ? sr_n[0] :
           state_n == PARITY ? par_n : UART_IDLE_LEVEL;
`else
    tx_n = state_n == START ? 1'b0 :
           state_n == DATA  ? sr_n[0] : UART_IDLE_LEVEL;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      idx   <= '0;
      tx    <= UART_IDLE_LEVEL;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      idx   <= idx_n;
      tx    <= tx_n;
    end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) par <= 1'b0;
    else     par <= par_n;
`endif
endmodule
